// File: rtl/sram_io_scheduler.sv
// Round-robin single-port SRAM scheduler between window-loader reads and
// edge-result writes, with per-anchor-step I/O accounting (io_final).
module sram_io_scheduler #(
    parameter int ADDR_BITS    = 16,
    parameter int DATA_BITS    = 8,
    parameter int SRAM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 anchor_moving,
    input  logic [3:0]           step_rd_count,
    input  logic [3:0]           step_wr_count,
    input  logic                 rd_req,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 rd_grant,
    output logic                 rd_valid,
    output logic [DATA_BITS-1:0] rd_data,
    input  logic                 wr_req,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_grant,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic                 io_final
);

    localparam int BW = $clog2(SRAM_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        COMPLETE
    } state_t;

    state_t        state;
    logic [3:0]    rd_cnt;
    logic [3:0]    wr_cnt;
    logic [4:0]    rd_iss;
    logic [4:0]    wr_iss;
    logic [4:0]    rd_done;
    logic [4:0]    wr_done;
    logic [BW-1:0] busy;
    logic          last_wr;

    logic rd_ok;
    logic wr_ok;
    logic last_beat;
    logic rd_fin;
    logic wr_fin;
    logic fin;

    assign rd_ok = (state == STEP) && (busy == '0) && !stop && rd_req
                   && (rd_iss < {1'b0, rd_cnt});
    assign wr_ok = (state == STEP) && (busy == '0) && !stop && wr_req
                   && (wr_iss < {1'b0, wr_cnt});

    // Ties go to whichever requester was not served last.
    assign rd_grant = rd_ok && (!wr_ok || last_wr);
    assign wr_grant = wr_ok && (!rd_ok || !last_wr);

    assign last_beat = (busy == BW'(1));
    assign rd_fin    = last_beat && mem_read;
    assign wr_fin    = last_beat && mem_write;
    assign fin = ((busy == '0) || last_beat)
                 && ((rd_done + 5'(rd_fin)) == {1'b0, rd_cnt})
                 && ((wr_done + 5'(wr_fin)) == {1'b0, wr_cnt});

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            rd_iss    <= '0;
            wr_iss    <= '0;
            rd_done   <= '0;
            wr_done   <= '0;
            busy      <= '0;
            last_wr   <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            io_final  <= 1'b0;
        end else if (stop) begin
            state     <= IDLE;
            busy      <= '0;
            rd_valid  <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            io_final  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= STEP;
                        rd_cnt  <= step_rd_count;
                        wr_cnt  <= step_wr_count;
                        rd_iss  <= '0;
                        wr_iss  <= '0;
                        rd_done <= '0;
                        wr_done <= '0;
                    end
                end
                STEP: begin
                    if (rd_grant || wr_grant) begin
                        mem_read  <= rd_grant;
                        mem_write <= wr_grant;
                        mem_addr  <= rd_grant ? rd_addr : wr_addr;
                        if (wr_grant)
                            mem_wdata <= wr_data;
                        busy    <= BW'(SRAM_LATENCY);
                        last_wr <= wr_grant;
                        rd_iss  <= rd_iss + 5'(rd_grant);
                        wr_iss  <= wr_iss + 5'(wr_grant);
                    end else if (busy != '0) begin
                        busy <= busy - BW'(1);
                        if (last_beat) begin
                            mem_read  <= 1'b0;
                            mem_write <= 1'b0;
                        end
                        if (rd_fin) begin
                            rd_data  <= mem_rdata;
                            rd_valid <= 1'b1;
                            rd_done  <= rd_done + 5'd1;
                        end
                        if (wr_fin)
                            wr_done <= wr_done + 5'd1;
                    end
                    if (fin) begin
                        state    <= COMPLETE;
                        io_final <= 1'b1;
                    end
                end
                COMPLETE: begin
                    if (anchor_moving) begin
                        state    <= STEP;
                        io_final <= 1'b0;
                        rd_cnt   <= step_rd_count;
                        wr_cnt   <= step_wr_count;
                        rd_iss   <= '0;
                        wr_iss   <= '0;
                        rd_done  <= '0;
                        wr_done  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sram_io_scheduler.md
Name: sram_io_scheduler

Overview:
- Shares the single-port pixel SRAM between two requesters: the window loader (reads) and the edge-result writer (writes).
- Issues one access at a time and arbitrates round-robin between the two requesters.
- Counts the reads and writes required for each anchor step and raises io_final when the step's I/O is complete.
- Sits between the filter pipeline and the SRAM, alongside the anchor controller; io_final feeds the anchor controller's all_final term.

Parameters:
- ADDR_BITS, 16, SRAM address width.
- DATA_BITS, 8, pixel width.
- SRAM_LATENCY, 2, cycles (>=1) that mem_read or mem_write is held per access; read data is valid in the last held cycle.

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset; asynchronous, active-low.
- start  in  1  pulse; begins the filtering phase.
- stop  in  1  pulse; ends the filtering phase (process_done).
- anchor_moving  in  1  anchor advances at this edge; opens a new step.
- step_rd_count  in  4  reads required per step.
- step_wr_count  in  4  writes required per step.
- rd_req  in  1  read request; held until rd_grant.
- rd_addr  in  ADDR_BITS  read address; stable while rd_req=1.
- rd_grant  out  1  combinational one-cycle pulse; read accepted.
- rd_valid  out  1  registered one-cycle pulse; rd_data valid.
- rd_data  out  DATA_BITS  read data.
- wr_req  in  1  write request; held until wr_grant.
- wr_addr  in  ADDR_BITS  write address.
- wr_data  in  DATA_BITS  write data.
- wr_grant  out  1  combinational one-cycle pulse; write accepted.
- mem_read  out  1  SRAM read strobe.
- mem_write  out  1  SRAM write strobe.
- mem_addr  out  ADDR_BITS  SRAM address.
- mem_wdata  out  DATA_BITS  SRAM write data.
- mem_rdata  in  DATA_BITS  SRAM read data.
- io_final  out  1  step I/O complete; level signal.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0, last_grant = write (so the first tie goes to read).
- FSM states: IDLE, STEP, COMPLETE.
  - IDLE -> STEP on start.
  - STEP -> COMPLETE at the edge where the completion of the final required access registers. If both step counts are 0, STEP -> COMPLETE at the next edge.
  - COMPLETE -> STEP on anchor_moving.
  - stop in any state -> IDLE at the next edge. An in-flight access is aborted, mem_* go to 0, and no rd_valid is issued for it.
  - stop has priority over anchor_moving and over completion.
- Step counts: step_rd_count and step_wr_count are latched on entry to STEP. On that same edge the issued and done counters clear.
- Grant conditions: a grant is possible only when state=STEP and no access is in flight (busy counter = 0).
  - rd_req is eligible only while rd_issued < latched read count; wr_req only while wr_issued < latched write count.
  - One eligible requester: it is granted.
  - Both eligible: grant the one opposite to last_grant.
  - last_grant updates on every grant.
- Access timing (grant at cycle t):
  - mem_read or mem_write, mem_addr and mem_wdata are registered and held for cycles t+1 .. t+SRAM_LATENCY.
  - For reads, rd_data is captured from mem_rdata in cycle t+SRAM_LATENCY; rd_valid pulses at t+SRAM_LATENCY+1.
  - A write completes at the same point; no pulse is issued for writes.
  - The earliest next grant is at t+SRAM_LATENCY+1, giving a throughput of 1 access per SRAM_LATENCY+1 cycles.
- mem_read and mem_write are never both 1. Both are 0 outside access windows; mem_addr holds its last value.
- Requests beyond the step count are not granted. They stay pending into the next step.
- Requests in IDLE or COMPLETE are never granted.
- io_final = (state == COMPLETE). It drops at the edge where anchor_moving is sampled.
- anchor_moving outside COMPLETE is ignored.
- Counters are 5 bits wide, so they cannot overflow at a count of 15.

Test Plan:
- Reset mid-access: with mem_read=1, drive n_rst low -> all outputs 0 immediately; after release, state is IDLE and there are no stray grants.
- Single read, SRAM_LATENCY=2, counts rd=1 wr=0: start, rd_req at t=5 with mem_rdata=0x3C during t=7 -> rd_grant at 5, mem_read at 6-7, rd_valid with rd_data=0x3C at 8, io_final high from 8.
- Contention, counts rd=2 wr=2, both requests held high -> grant order R,W,R,W at cycles spaced by 3; io_final rises 3 cycles after the last grant.
- Count limit, counts rd=1 wr=0, rd_req held high -> exactly one rd_grant; the request stays pending; after anchor_moving, a second grant follows in the new step.
- Zero counts rd=0 wr=0: start -> io_final high 1 cycle after STEP entry; anchor_moving -> io_final low for 1 cycle, then high again.
- stop during an in-flight write -> mem_write=0 at the next edge, state IDLE, io_final=0, no further grants.
